alu_pipe_param: RTL



---
 rtl/alu_pipe_param.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_pipe_param.sv
// alu_pipe_param: registered ALU (add/sub/compare/logic/shift) between operand issue and writeback; ALU_PIPE_MUL_EN adds multiply.
// Latency: 1 cycle per op; with ALU_PIPE_MUL_EN, opcode 1001 is a shift-add multiply with result WIDTH+1 cycles after accept.
// Backpressure: in_ready drops while en is low, while the output is stalled, or while a multiply is in flight.
module alu_pipe_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_LE  = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_LTU = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1001;
`endif

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             accept;
    logic             xfer;
    logic             is_mul;
    logic             idle;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             illegal_q, illegal_d;

    // Only the low SHW bits of B select the shift; upper bits are ignored.
    assign shamt = B[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (opcode)
            OP_ADD:  alu_res = A + B;
            OP_LE:   alu_res[0] = ($signed(A) <= $signed(B));
            OP_SUB:  alu_res = A - B;
            OP_LTU:  alu_res[0] = (A < B);
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLL:  alu_res = A << shamt;
            OP_SRA:  alu_res = $signed(A) >>> shamt;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  alu_ill = 1'b0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    assign xfer      = out_valid_q && out_ready;
    assign in_ready  = en && idle && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;

    assign is_mul   = (opcode == OP_MUL);
    assign idle     = (state_q == IDLE);
    assign mul_done = (state_q == DONE);
    assign mul_res  = acc_q;

    // One multiplier bit per BUSY cycle; the accumulator only keeps the low WIDTH bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && is_mul) begin
                        mcand_q  <= A;
                        mplier_q <= B;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign is_mul   = 1'b0;
    assign idle     = 1'b1;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
`endif

    // A new load always wins over a drain on the same edge, so out_valid stays high.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        illegal_d   = illegal_q;
        if (accept && !is_mul) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            illegal_d   = alu_ill;
        end else if (mul_done) begin
            out_valid_d = 1'b1;
            result_d    = mul_res;
            illegal_d   = 1'b0;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign illegal   = illegal_q;
endmodule
